// File: rtl/one_hot_detect_pkg.sv
// Shared helpers for the one-hot detector: index-width derivation and the
// registered flag bundle with its reset value.
package one_hot_detect_pkg;

    // Index width for a slice of w bits; a single bit still gets a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    typedef struct packed {
        logic onehot;
        logic zero;
        logic multi;
    } flags_t;

    localparam flags_t FlagsRst = '{onehot: 1'b0, zero: 1'b1, multi: 1'b0};

endpackage

// File: rtl/onehot_tree_node.sv
// Recursive reduction node: reports whether its slice has any bit set, more than
// one bit set, and the index of the highest-priority set bit within the slice.
module onehot_tree_node
    import one_hot_detect_pkg::*;
#(
    parameter  int unsigned WIDTH = 2,
    localparam int unsigned IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_din,
    output logic             o_any,
    output logic             o_multi,
    output logic [IDX_W-1:0] o_idx
);

    if (WIDTH == 1) begin : g_leaf
        assign o_any   = i_din[0];
        assign o_multi = 1'b0;
        assign o_idx   = '0;
    end else begin : g_split
        // Low child is the largest power of two below WIDTH, so the high child's
        // index only needs the top index bit prepended.
        localparam int unsigned LoW    = 1 << (IDX_W - 1);
        localparam int unsigned HiW    = WIDTH - LoW;
        localparam int unsigned LoIdxW = idx_width(LoW);
        localparam int unsigned HiIdxW = idx_width(HiW);

        logic              w_any_lo;
        logic              w_any_hi;
        logic              w_multi_lo;
        logic              w_multi_hi;
        logic [LoIdxW-1:0] w_idx_lo;
        logic [HiIdxW-1:0] w_idx_hi;

        onehot_tree_node #(
            .WIDTH (LoW)
        ) u_lo (
            .i_din   (i_din[LoW-1:0]),
            .o_any   (w_any_lo),
            .o_multi (w_multi_lo),
            .o_idx   (w_idx_lo)
        );

        onehot_tree_node #(
            .WIDTH (HiW)
        ) u_hi (
            .i_din   (i_din[WIDTH-1:LoW]),
            .o_any   (w_any_hi),
            .o_multi (w_multi_hi),
            .o_idx   (w_idx_hi)
        );

        assign o_any   = w_any_lo | w_any_hi;
        assign o_multi = w_multi_lo | w_multi_hi | (w_any_lo & w_any_hi);

        if (IDX_W == 1) begin : g_idx_bit
            // Both children are single-bit leaves with constant-zero indices.
            logic w_unused;
            assign w_unused = ^{w_idx_lo, w_idx_hi};
            assign o_idx    = w_any_hi;
        end else begin : g_idx_mux
            logic [IDX_W-2:0] w_idx_hi_ext;
            assign w_idx_hi_ext = (IDX_W - 1)'(w_idx_hi);
            assign o_idx = w_any_hi ? {1'b1, w_idx_hi_ext} : {1'b0, w_idx_lo};
        end
    end

endmodule

// File: rtl/one_hot_detect.sv
// Classifies a word as one-hot, zero or multi-hot with the set-bit index, both
// combinationally and through a one-cycle registered copy.
module one_hot_detect
    import one_hot_detect_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W      = idx_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  onehot,
    output logic                  zero,
    output logic                  multi,
    output logic [IDX_W-1:0]      idx,
    output logic                  onehot_q,
    output logic                  zero_q,
    output logic                  multi_q,
    output logic [IDX_W-1:0]      idx_q
);

    logic             w_any;
    logic             w_multi;
    logic [IDX_W-1:0] w_idx_raw;
    flags_t           w_flags;
    flags_t           r_flags;
    logic [IDX_W-1:0] r_idx;

    onehot_tree_node #(
        .WIDTH (DATA_WIDTH)
    ) u_root (
        .i_din   (din),
        .o_any   (w_any),
        .o_multi (w_multi),
        .o_idx   (w_idx_raw)
    );

    assign w_flags.onehot = w_any & ~w_multi;
    assign w_flags.zero   = ~w_any;
    assign w_flags.multi  = w_multi;

    assign onehot = w_flags.onehot;
    assign zero   = w_flags.zero;
    assign multi  = w_flags.multi;
    // The tree's index is meaningless unless exactly one bit is set.
    assign idx    = w_flags.onehot ? w_idx_raw : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= FlagsRst;
            r_idx   <= '0;
        end else begin
            r_flags <= w_flags;
            r_idx   <= idx;
        end
    end

    assign onehot_q = r_flags.onehot;
    assign zero_q   = r_flags.zero;
    assign multi_q  = r_flags.multi;
    assign idx_q    = r_idx;

endmodule

// File: tb/tb_one_hot_detect.sv
// Self-checking bench for one_hot_detect at widths 32, 1, 5 and 33 against a
// bit-counting reference model, with a scoreboard for the registered outputs.
module tb_one_hot_detect;

    typedef struct packed {
        logic       onehot;
        logic       zero;
        logic       multi;
        logic [5:0] idx;
    } exp_t;

    typedef struct packed {
        exp_t e32;
        exp_t e1;
        exp_t e5;
        exp_t e33;
    } rec_t;

    typedef struct {
        logic [31:0] din;
        logic        onehot;
        logic        zero;
        logic        multi;
        logic [4:0]  idx;
    } vec_t;

    localparam exp_t RstExp = '{onehot: 1'b0, zero: 1'b1, multi: 1'b0, idx: 6'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [31:0] din32 = '0;
    logic [0:0]  din1  = '0;
    logic [4:0]  din5  = '0;
    logic [32:0] din33 = '0;

    logic       oh32, z32, m32, ohq32, zq32, mq32;
    logic [4:0] idx32, idxq32;
    logic       oh1, z1, m1, ohq1, zq1, mq1;
    logic [0:0] idx1, idxq1;
    logic       oh5, z5, m5, ohq5, zq5, mq5;
    logic [2:0] idx5, idxq5;
    logic       oh33, z33, m33, ohq33, zq33, mq33;
    logic [5:0] idx33, idxq33;

    one_hot_detect #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .din(din32),
        .onehot(oh32), .zero(z32), .multi(m32), .idx(idx32),
        .onehot_q(ohq32), .zero_q(zq32), .multi_q(mq32), .idx_q(idxq32)
    );
    one_hot_detect #(.DATA_WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .din(din1),
        .onehot(oh1), .zero(z1), .multi(m1), .idx(idx1),
        .onehot_q(ohq1), .zero_q(zq1), .multi_q(mq1), .idx_q(idxq1)
    );
    one_hot_detect #(.DATA_WIDTH(5)) dut5 (
        .clk(clk), .reset(reset), .din(din5),
        .onehot(oh5), .zero(z5), .multi(m5), .idx(idx5),
        .onehot_q(ohq5), .zero_q(zq5), .multi_q(mq5), .idx_q(idxq5)
    );
    one_hot_detect #(.DATA_WIDTH(33)) dut33 (
        .clk(clk), .reset(reset), .din(din33),
        .onehot(oh33), .zero(z33), .multi(m33), .idx(idx33),
        .onehot_q(ohq33), .zero_q(zq33), .multi_q(mq33), .idx_q(idxq33)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    rec_t        sb[$];
    vec_t        vecs[11];

    function automatic exp_t model(input logic [63:0] v, input int w);
        exp_t        e;
        int unsigned cnt = 0;
        int unsigned pos = 0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                cnt++;
                pos = i;
            end
        end
        e.onehot = (cnt == 1);
        e.zero   = (cnt == 0);
        e.multi  = (cnt > 1);
        e.idx    = (cnt == 1) ? 6'(pos) : 6'd0;
        return e;
    endfunction

    task automatic chk(input string name, input exp_t act, input exp_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got oh=%b z=%b m=%b idx=%0d, want oh=%b z=%b m=%b idx=%0d",
                     name, act.onehot, act.zero, act.multi, act.idx,
                     exp.onehot, exp.zero, exp.multi, exp.idx);
        end
    endtask

    task automatic chk_excl(input string name, input logic oh, input logic z, input logic m);
        n_tests++;
        if ($countones({oh, z, m}) != 1) begin
            n_fail++;
            $display("FAIL %s exclusivity: got oh=%b z=%b m=%b, want exactly one set",
                     name, oh, z, m);
        end
    endtask

    task automatic pop_check();
        rec_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("reg32", {ohq32, zq32, mq32, 6'(idxq32)}, r.e32);
            chk("reg1",  {ohq1,  zq1,  mq1,  6'(idxq1)},  r.e1);
            chk("reg5",  {ohq5,  zq5,  mq5,  6'(idxq5)},  r.e5);
            chk("reg33", {ohq33, zq33, mq33, 6'(idxq33)}, r.e33);
        end
    endtask

    // Drive one word on the falling edge, check comb outputs, queue the
    // registered expectation for the next falling edge.
    task automatic apply(input logic [63:0] v, input logic rst);
        rec_t r;
        @(negedge clk);
        pop_check();
        reset = rst;
        din32 = v[31:0];
        din1  = v[0:0];
        din5  = v[4:0];
        din33 = v[32:0];
        #1;
        chk("comb32", {oh32, z32, m32, 6'(idx32)}, model(v, 32));
        chk("comb1",  {oh1,  z1,  m1,  6'(idx1)},  model(v, 1));
        chk("comb5",  {oh5,  z5,  m5,  6'(idx5)},  model(v, 5));
        chk("comb33", {oh33, z33, m33, 6'(idx33)}, model(v, 33));
        chk_excl("w32", oh32, z32, m32);
        chk_excl("w1",  oh1,  z1,  m1);
        chk_excl("w5",  oh5,  z5,  m5);
        chk_excl("w33", oh33, z33, m33);
        r.e32 = rst ? RstExp : model(v, 32);
        r.e1  = rst ? RstExp : model(v, 1);
        r.e5  = rst ? RstExp : model(v, 5);
        r.e33 = rst ? RstExp : model(v, 33);
        sb.push_back(r);
    endtask

    initial begin
        logic [63:0] v;

        vecs[0]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd0};
        vecs[1]  = '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[2]  = '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 5'd1};
        vecs[3]  = '{32'h0000_0008, 1'b1, 1'b0, 1'b0, 5'd3};
        vecs[4]  = '{32'h0000_8000, 1'b1, 1'b0, 1'b0, 5'd15};
        vecs[5]  = '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd31};
        vecs[6]  = '{32'h0000_0003, 1'b0, 1'b0, 1'b1, 5'd0};
        vecs[7]  = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd0};
        vecs[8]  = '{32'h8000_0001, 1'b0, 1'b0, 1'b1, 5'd0};
        vecs[9]  = '{32'h0001_0000, 1'b1, 1'b0, 1'b0, 5'd16};
        vecs[10] = '{32'h4000_4000, 1'b0, 1'b0, 1'b1, 5'd0};

        apply(64'h0, 1'b1);
        apply(64'h0, 1'b1);

        for (int i = 0; i < 11; i++) begin
            apply({32'h0, vecs[i].din}, 1'b0);
            chk("table", {oh32, z32, m32, 6'(idx32)},
                {vecs[i].onehot, vecs[i].zero, vecs[i].multi, 6'(vecs[i].idx)});
        end

        // Reset held over a one-hot word: comb stays live, registers stay reset.
        apply(64'h10, 1'b1);
        apply(64'h10, 1'b1);
        chk("rst_comb", {oh32, z32, m32, 6'(idx32)}, '{1'b1, 1'b0, 1'b0, 6'd4});
        @(posedge clk);
        #1;
        chk("rst_reg", {ohq32, zq32, mq32, 6'(idxq32)}, RstExp);
        apply(64'h10, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_release", {ohq32, zq32, mq32, 6'(idxq32)}, '{1'b1, 1'b0, 1'b0, 6'd4});

        for (int i = 0; i < 33; i++) begin
            apply(64'd1 << i, 1'b0);
        end
        for (int i = 0; i < 33; i++) begin
            for (int j = i + 1; j < 33; j++) begin
                apply((64'd1 << i) | (64'd1 << j), 1'b0);
            end
        end

        // Reset pulse in the middle of traffic.
        apply(64'h8000_0000, 1'b0);
        apply(64'h8000_0000, 1'b1);
        apply(64'h0000_0004, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            case (i % 3)
                0:       v = {$urandom, $urandom};
                1:       v = 64'd1 << $urandom_range(32, 0);
                default: v = (64'd1 << $urandom_range(32, 0)) | (64'd1 << $urandom_range(32, 0));
            endcase
            apply(v, 1'b0);
        end

        @(negedge clk);
        pop_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
